// File: rtl/mem_stage.sv
// Memory-access stage: performs byte-serial loads and stores over a byte-wide
// synchronous RAM port and stalls the pipeline while an access is in flight.
module mem_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  wd_i,
  input  logic        wreg_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] mem_addr_i,
  input  logic [31:0] store_data_i,
  input  logic [31:0] inst_i,
  input  logic [7:0]  mem_din_i,
  output logic [31:0] mem_a_o,
  output logic [7:0]  mem_dout_o,
  output logic        mem_wr_o,
  output logic [4:0]  wd_o,
  output logic        wreg_o,
  output logic [31:0] wdata_o,
  output logic        stall_req_o
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCESS,
    S_DONE
  } state_t;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;

  state_t      r_state;
  logic [2:0]  r_cnt;
  logic [31:0] r_buf;

  logic [6:0]  w_opcode;
  logic [2:0]  w_funct3;
  logic        w_isLoad;
  logic        w_isStore;
  logic [2:0]  w_size;
  logic [2:0]  w_idx;
  logic [31:0] w_addr;
  logic [7:0]  w_storeByte;
  logic [1:0]  w_bufIdx;
  logic [31:0] w_extData;
  logic        w_unusedInstBits;

  assign w_opcode = inst_i[6:0];
  assign w_funct3 = inst_i[14:12];
  assign w_unusedInstBits = ^{inst_i[31:15], inst_i[11:7]};

  always_comb begin
    w_isLoad  = 1'b0;
    w_isStore = 1'b0;
    if (w_opcode == OP_LOAD) begin
      case (w_funct3)
        3'b000, 3'b001, 3'b010, 3'b100, 3'b101: w_isLoad = 1'b1;
        default:                                w_isLoad = 1'b0;
      endcase
    end
    if (w_opcode == OP_STORE) begin
      case (w_funct3)
        3'b000, 3'b001, 3'b010: w_isStore = 1'b1;
        default:                w_isStore = 1'b0;
      endcase
    end
  end

  always_comb begin
    case (w_funct3[1:0])
      2'b00:   w_size = 3'd1;
      2'b01:   w_size = 3'd2;
      default: w_size = 3'd4;
    endcase
  end

  // Byte index being addressed this cycle: 0 on the IDLE cycle, cnt afterwards.
  always_comb begin
    w_idx = 3'd0;
    if (r_state == S_ACCESS) w_idx = r_cnt;
  end

  assign w_addr   = mem_addr_i + {29'd0, w_idx};
  assign w_bufIdx = r_cnt[1:0] - 2'd1;

  always_comb begin
    case (w_idx[1:0])
      2'd0:    w_storeByte = store_data_i[7:0];
      2'd1:    w_storeByte = store_data_i[15:8];
      2'd2:    w_storeByte = store_data_i[23:16];
      default: w_storeByte = store_data_i[31:24];
    endcase
  end

  always_comb begin
    case (w_funct3)
      3'b000:  w_extData = {{24{r_buf[7]}}, r_buf[7:0]};
      3'b001:  w_extData = {{16{r_buf[15]}}, r_buf[15:0]};
      3'b100:  w_extData = {24'd0, r_buf[7:0]};
      3'b101:  w_extData = {16'd0, r_buf[15:0]};
      default: w_extData = r_buf;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= 3'd0;
      r_buf   <= 32'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_isLoad) begin
            r_buf   <= 32'd0;
            r_cnt   <= 3'd1;
            r_state <= S_ACCESS;
          end else if (w_isStore) begin
            r_cnt   <= 3'd1;
            r_state <= (w_size == 3'd1) ? S_DONE : S_ACCESS;
          end
        end
        S_ACCESS: begin
          // Load data returns one cycle after its address, hence byte cnt-1.
          if (w_isLoad) begin
            case (w_bufIdx)
              2'd0:    r_buf[7:0]   <= mem_din_i;
              2'd1:    r_buf[15:8]  <= mem_din_i;
              2'd2:    r_buf[23:16] <= mem_din_i;
              default: r_buf[31:24] <= mem_din_i;
            endcase
            if (r_cnt == w_size) r_state <= S_DONE;
            else                 r_cnt   <= r_cnt + 3'd1;
          end else if (w_isStore) begin
            if (r_cnt == w_size - 3'd1) r_state <= S_DONE;
            else                        r_cnt   <= r_cnt + 3'd1;
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
          r_cnt   <= 3'd0;
        end
        default: begin
          r_state <= S_IDLE;
          r_cnt   <= 3'd0;
        end
      endcase
    end
  end

  always_comb begin
    mem_a_o     = 32'd0;
    mem_dout_o  = 8'd0;
    mem_wr_o    = 1'b0;
    wd_o        = 5'd0;
    wreg_o      = 1'b0;
    wdata_o     = 32'd0;
    stall_req_o = 1'b0;
    if (!rst) begin
      case (r_state)
        S_IDLE: begin
          if (w_isLoad || w_isStore) begin
            stall_req_o = 1'b1;
            wd_o        = wd_i;
            mem_a_o     = w_addr;
            if (w_isStore) begin
              mem_wr_o   = 1'b1;
              mem_dout_o = w_storeByte;
            end
          end else begin
            wd_o    = wd_i;
            wreg_o  = wreg_i;
            wdata_o = wdata_i;
          end
        end
        S_ACCESS: begin
          stall_req_o = 1'b1;
          wd_o        = wd_i;
          if (w_isLoad && (r_cnt < w_size)) begin
            mem_a_o = w_addr;
          end
          if (w_isStore) begin
            mem_wr_o   = 1'b1;
            mem_a_o    = w_addr;
            mem_dout_o = w_storeByte;
          end
        end
        S_DONE: begin
          wd_o = wd_i;
          if (w_isLoad) begin
            wreg_o  = wreg_i;
            wdata_o = w_extData;
          end
        end
        default: begin
          stall_req_o = 1'b0;
        end
      endcase
    end
  end

endmodule
